piano_scheduler: RTL

PIANO_SCHEDULER -- requirements
Module: piano_scheduler

---
 rtl/piano_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/piano_scheduler.sv
// Eight-key piano tone scheduler: synchronize and debounce raw keys, pick the highest pressed key,
// and drive a square wave whose half period is set by that key's divider.
module piano_scheduler #(
    parameter int unsigned DEBOUNCE = 250000,
    parameter logic [15:0] DIV0     = 16'd28409,
    parameter logic [15:0] DIV1     = 16'd25303,
    parameter logic [15:0] DIV2     = 16'd23900,
    parameter logic [15:0] DIV3     = 16'd21294,
    parameter logic [15:0] DIV4     = 16'd18968,
    parameter logic [15:0] DIV5     = 16'd17908,
    parameter logic [15:0] DIV6     = 16'd15943,
    parameter logic [15:0] DIV7     = 16'd14204
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keys,
    output logic       speaker,
    output logic       playing,
    output logic [2:0] note_idx
);

    localparam logic [17:0] DB_LAST = 18'(DEBOUNCE - 1);

    typedef enum logic {StIdle, StPlay} state_t;

    state_t      state;
    logic [7:0]  sync1, sync2, deb;
    logic [17:0] db_cnt [8];
    logic        arb_any;
    logic [2:0]  arb_sel;
    logic        sel_any;
    logic [2:0]  sel_idx;
    logic [15:0] tone_cnt;
    logic [15:0] cur_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    // A key level is accepted only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 18'd1;
                end
            end
        end
    end

    always_comb begin
        sel_any = |deb;
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (deb[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_any <= 1'b0;
            arb_sel <= 3'd0;
        end else begin
            arb_any <= sel_any;
            arb_sel <= sel_idx;
        end
    end

    always_comb begin
        cur_div = DIV0;
        case (note_idx)
            3'd0: cur_div = DIV0;
            3'd1: cur_div = DIV1;
            3'd2: cur_div = DIV2;
            3'd3: cur_div = DIV3;
            3'd4: cur_div = DIV4;
            3'd5: cur_div = DIV5;
            3'd6: cur_div = DIV6;
            3'd7: cur_div = DIV7;
            default: cur_div = DIV0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            speaker  <= 1'b0;
            playing  <= 1'b0;
            note_idx <= 3'd0;
            tone_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    speaker  <= 1'b0;
                    tone_cnt <= '0;
                    if (arb_any) begin
                        state    <= StPlay;
                        playing  <= 1'b1;
                        note_idx <= arb_sel;
                    end else begin
                        playing  <= 1'b0;
                        note_idx <= 3'd0;
                    end
                end
                StPlay: begin
                    if (!arb_any) begin
                        state    <= StIdle;
                        speaker  <= 1'b0;
                        playing  <= 1'b0;
                        note_idx <= 3'd0;
                        tone_cnt <= '0;
                    end else if (arb_sel != note_idx) begin
                        // New note restarts its phase without toggling.
                        note_idx <= arb_sel;
                        tone_cnt <= '0;
                    end else if (tone_cnt >= cur_div) begin
                        speaker  <= ~speaker;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    speaker  <= 1'b0;
                    playing  <= 1'b0;
                    note_idx <= 3'd0;
                    tone_cnt <= '0;
                end
            endcase
        end
    end

endmodule
